// File: rtl/div_ctrl_pkg.sv
// Shared types and parameter limits for the iterative-divider sequencer.
package div_ctrl_pkg;

    localparam int unsigned LAT_DEF   = 8;
    localparam int unsigned LAT_MIN   = 2;
    localparam int unsigned LAT_MAX   = 255;
    localparam int unsigned TAG_W_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_seq_ctrl_if.sv
// Request/step/completion bundle between a requester (master) and div_seq_ctrl (slave).
interface div_seq_ctrl_if
    import div_ctrl_pkg::*;
#(
    parameter int unsigned TAG_W = TAG_W_DEF,
    parameter int unsigned CNT_W = $clog2(LAT_DEF)
);

    logic             start;
    logic [TAG_W-1:0] start_tag;
    logic             abort;
    logic             step_en;
    logic [CNT_W-1:0] step_idx;
    logic             first;
    logic             out_valid;
    logic [TAG_W-1:0] out_tag;
    logic             busy;
    logic             overrun;

    modport master (
        output start, start_tag, abort,
        input  step_en, step_idx, first, out_valid, out_tag, busy, overrun
    );

    modport slave (
        input  start, start_tag, abort,
        output step_en, step_idx, first, out_valid, out_tag, busy, overrun
    );

endinterface

// File: rtl/div_iter_cnt.sv
// Iteration counter: counts 0..LAT-1 while enabled, flags the last iteration.
module div_iter_cnt
    import div_ctrl_pkg::*;
#(
    parameter int unsigned LAT = LAT_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    output logic [$clog2(LAT)-1:0]   cnt,
    output logic                     tc
);

    localparam int unsigned CNT_W = $clog2(LAT);

    // clear wins over enable so a wrap at LAT-1 never depends on power-of-two sizing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == CNT_W'(LAT - 1));

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequencer for multi-cycle iterative dividers: start -> LAT steps -> tagged completion.
// Define DIV_SEQ_CTRL_PEND_EN to build the one-deep pending request slot.
module div_seq_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int unsigned LAT   = LAT_DEF,
    parameter int unsigned TAG_W = TAG_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    div_seq_ctrl_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(LAT);

    if ((LAT < LAT_MIN) || (LAT > LAT_MAX)) begin : g_lat_range
        $error("div_seq_ctrl: LAT outside supported range");
    end

    state_t             state;
    state_t             state_n;
    logic [TAG_W-1:0]   cur_tag;
    logic [TAG_W-1:0]   cur_tag_n;
    logic [TAG_W-1:0]   out_tag_q;
    logic [TAG_W-1:0]   out_tag_n;
    logic               overrun_q;
    logic               overrun_n;
`ifdef DIV_SEQ_CTRL_PEND_EN
    logic               pend_full;
    logic               pend_full_n;
    logic [TAG_W-1:0]   pend_tag;
    logic [TAG_W-1:0]   pend_tag_n;
`endif

    logic [CNT_W-1:0]   cnt;
    logic               cnt_tc;
    logic               cnt_clr_c;
    logic               cnt_en_c;
    logic               step_en_c;
    logic [CNT_W-1:0]   step_idx_c;
    logic               first_c;
    logic               out_valid_c;
    logic               busy_c;

    div_iter_cnt #(.LAT(LAT)) u_iter_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr_c),
        .en  (cnt_en_c),
        .cnt (cnt),
        .tc  (cnt_tc)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // tag, completion and pending registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_tag   <= '0;
            out_tag_q <= '0;
            overrun_q <= 1'b0;
`ifdef DIV_SEQ_CTRL_PEND_EN
            pend_full <= 1'b0;
            pend_tag  <= '0;
`endif
        end else begin
            cur_tag   <= cur_tag_n;
            out_tag_q <= out_tag_n;
            overrun_q <= overrun_n;
`ifdef DIV_SEQ_CTRL_PEND_EN
            pend_full <= pend_full_n;
            pend_tag  <= pend_tag_n;
`endif
        end
    end

    // next-state and next-register values
    always_comb begin
        state_n   = state;
        cur_tag_n = cur_tag;
        out_tag_n = out_tag_q;
        overrun_n = overrun_q;
`ifdef DIV_SEQ_CTRL_PEND_EN
        pend_full_n = pend_full;
        pend_tag_n  = pend_tag;
`endif
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n   = RUN;
                    cur_tag_n = bus.start_tag;
                end
            end
            RUN: begin
                if (cnt_tc) begin
                    state_n   = DONE;
                    out_tag_n = cur_tag;
                end
                if (bus.start) begin
`ifdef DIV_SEQ_CTRL_PEND_EN
                    if (!pend_full) begin
                        pend_full_n = 1'b1;
                        pend_tag_n  = bus.start_tag;
                    end else begin
                        overrun_n = 1'b1;
                    end
`else
                    overrun_n = 1'b1;
`endif
                end
            end
            DONE: begin
`ifdef DIV_SEQ_CTRL_PEND_EN
                // slot is dequeued this cycle, so a new start can refill it
                if (pend_full) begin
                    state_n     = RUN;
                    cur_tag_n   = pend_tag;
                    pend_full_n = 1'b0;
                    if (bus.start) begin
                        pend_full_n = 1'b1;
                        pend_tag_n  = bus.start_tag;
                    end
                end else if (bus.start) begin
                    state_n   = RUN;
                    cur_tag_n = bus.start_tag;
                end else begin
                    state_n = IDLE;
                end
`else
                if (bus.start) begin
                    state_n   = RUN;
                    cur_tag_n = bus.start_tag;
                end else begin
                    state_n = IDLE;
                end
`endif
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // abort discards running and queued work; out_tag keeps its last completion
        if (bus.abort) begin
            state_n   = IDLE;
            out_tag_n = out_tag_q;
            overrun_n = 1'b0;
`ifdef DIV_SEQ_CTRL_PEND_EN
            pend_full_n = 1'b0;
`endif
        end
    end

    // output decode from registered state only
    always_comb begin
        step_en_c   = (state == RUN);
        step_idx_c  = step_en_c ? cnt : '0;
        first_c     = step_en_c && (cnt == '0);
        out_valid_c = (state == DONE);
        cnt_en_c    = step_en_c;
        cnt_clr_c   = bus.abort || (step_en_c && cnt_tc);
`ifdef DIV_SEQ_CTRL_PEND_EN
        busy_c      = (state != IDLE) || pend_full;
`else
        busy_c      = (state != IDLE);
`endif
    end

    assign bus.step_en   = step_en_c;
    assign bus.step_idx  = step_idx_c;
    assign bus.first     = first_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_tag   = out_tag_q;
    assign bus.busy      = busy_c;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl (LAT=8 main instance, LAT=2 latency instance).
module tb_div_seq_ctrl;
    import div_ctrl_pkg::*;

    localparam int unsigned LAT_A = 8;
    localparam int unsigned LAT_B = 2;
    localparam int unsigned TW    = 2;

    typedef struct packed {
        logic [TW-1:0] tag;
        int            cyc;
    } exp_t;

    // per-scenario stimulus and expected windows; s<0 means unused, empty window is (-1,-2)
    typedef struct packed {
        int ncyc;
        int s0; int s1; int s2;
        int t0; int t1; int t2;
        int x0; int x1; int x2;
        int ab;
        int r0s; int r0e; int r1s; int r1e;
        int bs;  int be;
        int os;  int oe;
    } scn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   base = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    div_seq_ctrl_if #(.TAG_W(TW), .CNT_W($clog2(LAT_A))) bus_a ();
    div_seq_ctrl_if #(.TAG_W(TW), .CNT_W($clog2(LAT_B))) bus_b ();

    div_seq_ctrl #(.LAT(LAT_A), .TAG_W(TW)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    div_seq_ctrl #(.LAT(LAT_B), .TAG_W(TW)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    task automatic chk(input string name, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    function automatic exp_t mk_exp(input int tag, input int c);
        exp_t e;
        e.tag = TW'(tag);
        e.cyc = c;
        return e;
    endfunction

    // completion monitor: every out_valid must match the oldest expected entry
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && bus_a.out_valid) begin
            if (sb.size() == 0) begin
                chk($sformatf("unexpected_out_valid_c%0d", cyc - base), 1, 0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("out_tag_c%0d", cyc - base), int'(bus_a.out_tag), int'(e.tag));
                chk("out_valid_cycle", cyc - base, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cycle(input int tn, input int c, input scn_t s);
        int e_en, e_idx, e_first;
        e_en = 0; e_idx = 0; e_first = 0;
        if (c >= s.r0s && c <= s.r0e) begin
            e_en = 1; e_idx = c - s.r0s; e_first = int'(c == s.r0s);
        end else if (c >= s.r1s && c <= s.r1e) begin
            e_en = 1; e_idx = c - s.r1s; e_first = int'(c == s.r1s);
        end
        chk($sformatf("t%0d_c%0d_step_en", tn, c), int'(bus_a.step_en), e_en);
        chk($sformatf("t%0d_c%0d_step_idx", tn, c), int'(bus_a.step_idx), e_idx);
        chk($sformatf("t%0d_c%0d_first", tn, c), int'(bus_a.first), e_first);
        chk($sformatf("t%0d_c%0d_busy", tn, c), int'(bus_a.busy), int'(c >= s.bs && c <= s.be));
        chk($sformatf("t%0d_c%0d_overrun", tn, c), int'(bus_a.overrun), int'(c >= s.os && c <= s.oe));
    endtask

    task automatic run_scn(input int tn, input scn_t s);
        base = cyc;
        for (int c = 0; c < s.ncyc; c++) begin
            bus_a.start     = (c == s.s0) || (c == s.s1) || (c == s.s2);
            bus_a.start_tag = (c == s.s1) ? TW'(s.t1) : (c == s.s2) ? TW'(s.t2) : TW'(s.t0);
            bus_a.abort     = (c == s.ab);
            if (c == s.s0 && s.x0 >= 0) sb.push_back(mk_exp(s.t0, s.x0));
            if (c == s.s1 && s.x1 >= 0) sb.push_back(mk_exp(s.t1, s.x1));
            if (c == s.s2 && s.x2 >= 0) sb.push_back(mk_exp(s.t2, s.x2));
            chk_cycle(tn, c, s);
            tick();
        end
        bus_a.start = 1'b0;
        bus_a.abort = 1'b0;
        chk($sformatf("t%0d_scoreboard_drained", tn), sb.size(), 0);
        sb.delete();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.start_tag = '0;
        bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.start_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_step_en"},   int'(bus_a.step_en),   0);
        chk({pfx, "_step_idx"},  int'(bus_a.step_idx),  0);
        chk({pfx, "_first"},     int'(bus_a.first),     0);
        chk({pfx, "_out_valid"}, int'(bus_a.out_valid), 0);
        chk({pfx, "_out_tag"},   int'(bus_a.out_tag),   0);
        chk({pfx, "_busy"},      int'(bus_a.busy),      0);
        chk({pfx, "_overrun"},   int'(bus_a.overrun),   0);
    endtask

    initial begin
        scn_t t1, t2, t3, t4, t5, t6;
        t1 = '{12, 0,-1,-1, 2,0,0, 9,-1,-1, -1, 1,8,-1,-2, 1,9, -1,-2};
        t3 = '{20, 0,9,-1,  1,3,0, 9,18,-1, -1, 1,8,10,17, 1,18, -1,-2};
`ifdef DIV_SEQ_CTRL_PEND_EN
        t2 = '{21, 0,3,-1,  1,2,0, 9,18,-1, -1, 1,8,10,17, 1,18, -1,-2};
        t4 = '{22, 0,2,4,   0,1,2, 9,18,-1, 20, 1,8,10,17, 1,18, 5,20};
        t5 = '{31, 0,2,5,   1,2,3, -1,-1,-1, 5, 1,5,-1,-2, 1,5, -1,-2};
`else
        t2 = '{21, 0,3,-1,  1,2,0, 9,-1,-1, -1, 1,8,-1,-2, 1,9, 4,20};
        t4 = '{22, 0,2,4,   0,1,2, 9,-1,-1, 20, 1,8,-1,-2, 1,9, 3,20};
        t5 = '{31, 0,2,5,   1,2,3, -1,-1,-1, 5, 1,5,-1,-2, 1,5, 3,5};
`endif
        t6 = '{5,  0,-1,-1, 1,0,0, -1,-1,-1, -1, 1,8,-1,-2, 1,8, -1,-2};

        bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.start_tag = '0;
        bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.start_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        run_scn(1, t1);
        chk("t1_out_tag_hold", int'(bus_a.out_tag), 2);
        apply_reset();
        run_scn(2, t2);
        apply_reset();
        run_scn(3, t3);
        apply_reset();
        run_scn(4, t4);
        apply_reset();
        run_scn(5, t5);
        chk("t5_out_tag_after_abort", int'(bus_a.out_tag), 0);

        // async reset in the 4th RUN cycle, checked before the next edge
        base = cyc;
        for (int c = 0; c <= 4; c++) begin
            bus_a.start     = (c == 0);
            bus_a.start_tag = TW'(1);
            chk_cycle(6, c, t6);
            if (c < 4) tick();
        end
        bus_a.start = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("midreset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            chk($sformatf("post_reset_c%0d_step_en", c), int'(bus_a.step_en), 0);
            chk($sformatf("post_reset_c%0d_busy", c), int'(bus_a.busy), 0);
            tick();
        end

        // LAT=2 instance: start at cycle 0 completes in cycle 3
        for (int c = 0; c < 6; c++) begin
            bus_b.start     = (c == 0);
            bus_b.start_tag = TW'(3);
            chk($sformatf("lat2_c%0d_step_en", c), int'(bus_b.step_en), int'(c == 1 || c == 2));
            chk($sformatf("lat2_c%0d_step_idx", c), int'(bus_b.step_idx), (c == 2) ? 1 : 0);
            chk($sformatf("lat2_c%0d_out_valid", c), int'(bus_b.out_valid), int'(c == 3));
            chk($sformatf("lat2_c%0d_busy", c), int'(bus_b.busy), int'(c >= 1 && c <= 3));
            if (c == 3) chk("lat2_out_tag", int'(bus_b.out_tag), 3);
            tick();
        end
        bus_b.start = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
